decode_stage: RTL and testbench
===============================

# decode_stage

RV32I instruction-decode stage: takes the fetched instruction from IF/ID, drives the register-file read addresses, captures operands and decoded control into the ID/EX pipeline register. Sits between fetch and execute, directly upstream of the register file's read ports. Also detects load-use hazards and, optionally, bypasses same-cycle writeback data.

## Interface
- WORD_SIZE, 32, datapath width; only 32 is supported.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_valid / if_instr / if_pc  in  1 / 32 / 32  IF/ID instruction, its valid flag and its PC.
- stall  in  1  downstream stall; hold every ID/EX register.
- flush  in  1  branch/jump redirect; kill the instruction entering ID/EX.
- rf_a1, rf_a2  out  5 each  register-file read addresses, set to if_instr[19:15] and if_instr[24:20].
- rf_a_data, rf_b_data  in  32 each  register-file read data; x0 reads 0.
- wb_en / wb_rd / wb_data  in  1 / 5 / 32  writeback port driven into the register file this cycle.
- hazard_stall  out  1  load-use stall request to fetch (hold IF/ID).
- ex_valid  out  1  ID/EX entry valid.
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  32 each  PC, operands, sign-extended immediate.
- ex_rs1, ex_rs2, ex_rd  out  5 each  register indices.
- ex_alu_op  out  4  {funct7[5] qualifier, funct3}; 4'b0000 = ADD.
- ex_funct3  out  3  raw funct3 for branch, load and store use.
- ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_illegal  out  1 each  control flags.

## Operation
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- Any other opcode sets ex_illegal=1 and forces reg_write, mem_read, mem_write, branch and jump to 0.
- Immediates use I/S/B/U/J formats, sign-extended from bit 31. U-type is {instr[31:12],12'b0}. B and J immediates have bit 0 = 0.
- alu_op:
  - OP uses {instr[30],funct3}.
  - OP-IMM uses {instr[30],funct3} when funct3=101, otherwise {0,funct3}.
  - All other opcodes use 0000.
- alu_src_imm=1 for every opcode except OP and BRANCH.
- reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP. It is forced to 0 when rd=0.
- jump=1 for JAL and JALR. branch=1 for BRANCH.
- Register use for hazards: rs1 is used by all opcodes except LUI, AUIPC and JAL. rs2 is used by BRANCH, STORE and OP.
- Load-use hazard: hazard_stall = if_valid & ex_valid & ex_mem_read & (ex_rd≠0) & ((rs1 used & ex_rd==rs1) | (rs2 used & ex_rd==rs2)).
- ID/EX update priority on each edge:
  - flush: ex_valid←0.
  - else stall: hold all registers.
  - else hazard_stall: ex_valid←0 (bubble).
  - else load all fields; ex_valid←if_valid.
- When ex_valid=0, the other ex_* fields are don't-care. The bench checks them only when ex_valid=1.

## Timing
- Reset: every ex_* output is 0. hazard_stall reads 0 because ex_valid=0.
- rf_a1, rf_a2 and hazard_stall are combinational from the current inputs and ID/EX state.
- Latency is 1 cycle from if_instr to the ex_* outputs.
- A load-use hazard inserts exactly one bubble. On the next cycle the load sits in EX of the following stage, so ex_mem_read=0 for the bubble and hazard_stall deasserts.
- stall and hazard together: the stall hold wins; hazard_stall stays asserted.
- flush in the same cycle as stall or hazard: bubble inserted.
- rst asserted mid-operation clears state immediately, with no edge needed.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - When wb_en & wb_rd≠0 & wb_rd==rs1, capture wb_data instead of rf_a_data.
  - The same rule applies to rs2 with rf_b_data.
  - This covers the register file's write-on-edge read staleness.
- Undefined: operands come straight from rf_a_data and rf_b_data. Software or the pipeline must separate dependent instructions by one cycle.

## Test plan
- ADDI x1,x0,5 (0x00500093), if_valid=1 -> next cycle ex_valid=1, ex_imm=5, ex_rd=1, ex_rs1=0, ex_alu_op=0000, ex_alu_src_imm=1, ex_reg_write=1.
- LW x2,0(x1) (0x0000A103) then ADD x3,x2,x2 (0x002101B3) -> hazard_stall=1 for exactly one cycle, one ex_valid=0 bubble, then the ADD issues with ex_rs1=ex_rs2=2.
- BEQ x0,x0,-4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC, ex_branch=1, ex_reg_write=0, ex_alu_src_imm=0.
- ADD x3,x2,x2 with rf data 0 and wb_en=1, wb_rd=2, wb_data=0xDEADBEEF -> ex_rs1_val=ex_rs2_val=0xDEADBEEF with the macro, 0 without. With wb_rd=0 the operands stay 0 in both builds.
- 0xFFFFFFFF -> ex_illegal=1 with all write and memory controls 0. ADDI x0,x0,0 -> ex_reg_write=0.
- stall held for 3 cycles while if_instr changes -> ex_* unchanged. flush together with stall -> ex_valid=0. rst mid-stream -> all ex_* go to 0 immediately.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the IF/ID instruction, reads the register file,
// detects load-use hazards and fills the ID/EX pipeline register. Optional
// same-cycle writeback bypass is enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic [31:0]          if_instr,
  input  logic [WORD_SIZE-1:0] if_pc,
  input  logic                 stall,
  input  logic                 flush,
  output logic [4:0]           rf_a1,
  output logic [4:0]           rf_a2,
  input  logic [WORD_SIZE-1:0] rf_a_data,
  input  logic [WORD_SIZE-1:0] rf_b_data,
  input  logic                 wb_en,
  input  logic [4:0]           wb_rd,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 hazard_stall,
  output logic                 ex_valid,
  output logic [WORD_SIZE-1:0] ex_pc,
  output logic [WORD_SIZE-1:0] ex_rs1_val,
  output logic [WORD_SIZE-1:0] ex_rs2_val,
  output logic [WORD_SIZE-1:0] ex_imm,
  output logic [4:0]           ex_rs1,
  output logic [4:0]           ex_rs2,
  output logic [4:0]           ex_rd,
  output logic [3:0]           ex_alu_op,
  output logic [2:0]           ex_funct3,
  output logic                 ex_alu_src_imm,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_reg_write,
  output logic                 ex_branch,
  output logic                 ex_jump,
  output logic                 ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign funct3 = if_instr[14:12];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rf_a1  = rs1;
  assign rf_a2  = rs2;

  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                  if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'b0};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};

  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic alu_src_imm, mem_read, mem_write, reg_write, branch, jump, illegal;
  logic rs1_used, rs2_used;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    imm         = '0;
    alu_op      = 4'b0000;
    alu_src_imm = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    illegal     = 1'b0;
    rs1_used    = 1'b1;
    rs2_used    = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        imm       = imm_u;
        reg_write = 1'b1;
        rs1_used  = 1'b0;
      end
      OPC_JAL: begin
        imm       = imm_j;
        reg_write = 1'b1;
        jump      = 1'b1;
        rs1_used  = 1'b0;
      end
      OPC_JALR: begin
        imm       = imm_i;
        reg_write = 1'b1;
        jump      = 1'b1;
      end
      OPC_BRANCH: begin
        imm         = imm_b;
        branch      = 1'b1;
        alu_src_imm = 1'b0;
        rs2_used    = 1'b1;
      end
      OPC_LOAD: begin
        imm       = imm_i;
        mem_read  = 1'b1;
        reg_write = 1'b1;
      end
      OPC_STORE: begin
        imm       = imm_s;
        mem_write = 1'b1;
        rs2_used  = 1'b1;
      end
      OPC_OP_IMM: begin
        imm       = imm_i;
        reg_write = 1'b1;
        // Only the shifts carry a funct7 qualifier; elsewhere bit 30 is immediate data.
        alu_op    = (funct3 == 3'b101) ? {if_instr[30], funct3} : {1'b0, funct3};
      end
      OPC_OP: begin
        alu_src_imm = 1'b0;
        reg_write   = 1'b1;
        rs2_used    = 1'b1;
        alu_op      = {if_instr[30], funct3};
      end
      default: illegal = 1'b1;
    endcase
    if (rd == 5'd0) reg_write = 1'b0;
  end

  assign hazard_stall = if_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                        ((rs1_used && (ex_rd == rs1)) || (rs2_used && (ex_rd == rs2)));

  logic [WORD_SIZE-1:0] rs1_val, rs2_val;

`ifdef DECODE_WB_BYPASS_EN
  // The register file writes on the same edge we capture, so its read port is stale.
  assign rs1_val = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1)) ? wb_data : rf_a_data;
  assign rs2_val = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2)) ? wb_data : rf_b_data;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_rd, wb_data};
  assign rs1_val   = rf_a_data;
  assign rs2_val   = rf_b_data;
`endif

  // NOTE: pipeline state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1_val     <= '0;
      ex_rs2_val     <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_alu_op      <= '0;
      ex_funct3      <= '0;
      ex_alu_src_imm <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
      ex_illegal     <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (stall) begin
      ex_valid <= ex_valid;
    end else if (hazard_stall) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid       <= if_valid;
      ex_pc          <= if_pc;
      ex_rs1_val     <= rs1_val;
      ex_rs2_val     <= rs2_val;
      ex_imm         <= imm;
      ex_rs1         <= rs1;
      ex_rs2         <= rs2;
      ex_rd          <= rd;
      ex_alu_op      <= alu_op;
      ex_funct3      <= funct3;
      ex_alu_src_imm <= alu_src_imm;
      ex_mem_read    <= mem_read;
      ex_mem_write   <= mem_write;
      ex_reg_write   <= reg_write;
      ex_branch      <= branch;
      ex_jump        <= jump;
      ex_illegal     <= illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table followed by hand-written
// load-use, bypass, stall, flush and asynchronous-reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_a_data = '0;
  logic [31:0] rf_b_data = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic        ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_branch, ex_jump, ex_illegal;

  decode_stage #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .stall(stall), .flush(flush),
    .rf_a1(rf_a1), .rf_a2(rf_a2),
    .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flags = {mem_read, mem_write, reg_write, branch, jump, illegal}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        chk_imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        src;
    logic        chk_src;
    logic [5:0]  flags;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] imm,
                              input logic chk_imm, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [3:0] alu,
                              input logic src, input logic chk_src, input logic [5:0] flags);
    vec_t v;
    v.instr = instr; v.imm = imm; v.chk_imm = chk_imm;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.alu = alu;
    v.src = src; v.chk_src = chk_src; v.flags = flags;
    return v;
  endfunction

  function automatic logic any_ex();
    return |{ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_alu_op, ex_funct3, ex_alu_src_imm, ex_mem_read, ex_mem_write,
             ex_reg_write, ex_branch, ex_jump, ex_illegal};
  endfunction

  localparam logic [31:0] I_ADDI_X1 = 32'h00500093;
  localparam logic [31:0] I_LW_X2   = 32'h0000A103;
  localparam logic [31:0] I_ADD_X3  = 32'h002101B3;

  vec_t vecs[14];
  logic [31:0] bypass_exp;

  initial begin
    vecs[0]  = mk(32'h00500093, 32'h00000005, 1,  1,  0,  5, 3'd0, 4'b0000, 1, 1, 6'b001000);
    vecs[1]  = mk(32'hFE000EE3, 32'hFFFFFFFC, 1, 29,  0,  0, 3'd0, 4'b0000, 0, 1, 6'b000100);
    vecs[2]  = mk(32'h123452B7, 32'h12345000, 1,  5,  8,  3, 3'd5, 4'b0000, 1, 1, 6'b001000);
    vecs[3]  = mk(32'hFFFFF317, 32'hFFFFF000, 1,  6, 31, 31, 3'd7, 4'b0000, 1, 1, 6'b001000);
    vecs[4]  = mk(32'h008000EF, 32'h00000008, 1,  1,  0,  8, 3'd0, 4'b0000, 1, 1, 6'b001010);
    vecs[5]  = mk(32'hFFDFF06F, 32'hFFFFFFFC, 1,  0, 31, 29, 3'd7, 4'b0000, 1, 1, 6'b000010);
    vecs[6]  = mk(32'h010280E7, 32'h00000010, 1,  1,  5, 16, 3'd0, 4'b0000, 1, 1, 6'b001010);
    vecs[7]  = mk(32'hFE712C23, 32'hFFFFFFF8, 1, 24,  2,  7, 3'd2, 4'b0000, 1, 1, 6'b010000);
    vecs[8]  = mk(32'h4031D213, 32'h00000403, 1,  4,  3,  3, 3'd5, 4'b1101, 1, 1, 6'b001000);
    vecs[9]  = mk(32'hC001C213, 32'hFFFFFC00, 1,  4,  3,  0, 3'd4, 4'b0100, 1, 1, 6'b001000);
    vecs[10] = mk(32'h407302B3, 32'h00000000, 0,  5,  6,  7, 3'd0, 4'b1000, 0, 1, 6'b001000);
    vecs[11] = mk(32'h0000A103, 32'h00000000, 1,  2,  1,  0, 3'd2, 4'b0000, 1, 1, 6'b101000);
    vecs[12] = mk(32'hFFFFFFFF, 32'h00000000, 0, 31, 31, 31, 3'd7, 4'b0000, 0, 0, 6'b000001);
    vecs[13] = mk(32'h00000013, 32'h00000000, 1,  0,  0,  0, 3'd0, 4'b0000, 1, 1, 6'b000000);

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b1;
    #2;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_fields", any_ex(), 0);
    check("rst_hazard", hazard_stall, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Decode table.
    for (int i = 0; i < 14; i++) begin
      if_valid  = 1'b1;
      if_instr  = vecs[i].instr;
      if_pc     = 32'h1000 + 32'(i) * 4;
      rf_a_data = 32'h10000000 + 32'(i);
      rf_b_data = 32'h20000000 + 32'(i);
      #1;
      check($sformatf("v%0d_rf_a1", i), rf_a1, vecs[i].rs1);
      check($sformatf("v%0d_rf_a2", i), rf_a2, vecs[i].rs2);
      step();
      check($sformatf("v%0d_valid", i), ex_valid, 1);
      check($sformatf("v%0d_pc", i), ex_pc, 32'h1000 + 32'(i) * 4);
      check($sformatf("v%0d_rs1_val", i), ex_rs1_val, 32'h10000000 + 32'(i));
      check($sformatf("v%0d_rs2_val", i), ex_rs2_val, 32'h20000000 + 32'(i));
      if (vecs[i].chk_imm) check($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
      check($sformatf("v%0d_rd", i), ex_rd, vecs[i].rd);
      check($sformatf("v%0d_rs1", i), ex_rs1, vecs[i].rs1);
      check($sformatf("v%0d_rs2", i), ex_rs2, vecs[i].rs2);
      check($sformatf("v%0d_funct3", i), ex_funct3, vecs[i].f3);
      check($sformatf("v%0d_alu_op", i), ex_alu_op, vecs[i].alu);
      if (vecs[i].chk_src) check($sformatf("v%0d_alu_src", i), ex_alu_src_imm, vecs[i].src);
      check($sformatf("v%0d_flags", i),
            {ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_illegal},
            vecs[i].flags);
    end

    // Load-use: one bubble, then the dependent ADD issues.
    rf_a_data = '0;
    rf_b_data = '0;
    if_instr  = I_LW_X2;
    step();
    check("lu_load_in_ex", {ex_valid, ex_mem_read}, 2'b11);
    if_instr = I_ADD_X3;
    #1;
    check("lu_hazard_on", hazard_stall, 1);
    step();
    check("lu_bubble", ex_valid, 0);
    check("lu_hazard_off", hazard_stall, 0);
    step();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_regs", {ex_rs1, ex_rs2, ex_rd}, {5'd2, 5'd2, 5'd3});
    check("lu_add_ctrl", {ex_alu_op, ex_reg_write, ex_mem_read}, {4'b0000, 1'b1, 1'b0});
    check("lu_no_rehazard", hazard_stall, 0);

    // Writeback bypass (build dependent), then wb_rd=0 never bypasses.
`ifdef DECODE_WB_BYPASS_EN
    bypass_exp = 32'hDEADBEEF;
`else
    bypass_exp = 32'h00000000;
`endif
    wb_en   = 1'b1;
    wb_rd   = 5'd2;
    wb_data = 32'hDEADBEEF;
    step();
    check("byp_rs1_val", ex_rs1_val, bypass_exp);
    check("byp_rs2_val", ex_rs2_val, bypass_exp);
    wb_rd = 5'd0;
    step();
    check("byp_x0_rs1", ex_rs1_val, 0);
    check("byp_x0_rs2", ex_rs2_val, 0);
    wb_en = 1'b0;

    // Stall holds ID/EX while the instruction changes underneath.
    if_instr = I_ADDI_X1;
    if_pc    = 32'h200;
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_instr = (k == 0) ? 32'h123452B7 : (k == 1) ? 32'h407302B3 : 32'hFFFFFFFF;
      if_pc    = 32'h300 + 32'(k);
      step();
      check($sformatf("stall%0d_valid", k), ex_valid, 1);
      check($sformatf("stall%0d_imm", k), ex_imm, 5);
      check($sformatf("stall%0d_pc", k), ex_pc, 32'h200);
      check($sformatf("stall%0d_ctrl", k), {ex_rd, ex_reg_write, ex_illegal}, {5'd1, 1'b1, 1'b0});
    end

    // Stall over a hazard: hold wins and hazard stays up; then flush with stall.
    stall    = 1'b0;
    if_instr = I_LW_X2;
    step();
    stall    = 1'b1;
    if_instr = I_ADD_X3;
    step();
    check("sh_load_held", {ex_valid, ex_mem_read, ex_rd}, {1'b1, 1'b1, 5'd2});
    check("sh_hazard_held", hazard_stall, 1);
    flush = 1'b1;
    step();
    check("flush_stall_bubble", ex_valid, 0);
    check("flush_stall_no_hazard", hazard_stall, 0);
    stall = 1'b0;
    flush = 1'b0;

    // Flush over a hazard also gives a bubble.
    if_instr = I_LW_X2;
    step();
    if_instr = I_ADD_X3;
    flush    = 1'b1;
    #1;
    check("fh_hazard_on", hazard_stall, 1);
    step();
    check("flush_hazard_bubble", ex_valid, 0);
    flush = 1'b0;

    // Reset mid-stream clears state without an edge.
    if_instr = I_ADDI_X1;
    step();
    check("mid_valid_before_rst", ex_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", ex_valid, 0);
    check("mid_rst_fields", any_ex(), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
